// File: rtl/mem_unified_hs.sv
// Unified instruction/data memory with a valid/ready request handshake,
// configurable wait states, byte-lane write strobes and address wrap.
module mem_unified_hs #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 1,
  parameter     INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic              w_accept, w_access, w_wr_legal;

  logic              r_we;
  logic [IDX_W-1:0]  r_idx;
  logic [1:0]        r_off;
  logic [31:0]       r_wdata;
  logic [3:0]        r_be;

  logic [31:0]       r_mem [DEPTH_WORDS];
  logic [31:0]       r_rdata;
  logic              r_err;

  // Upper address bits only select aliases of the same word.
  logic              w_unused_addr;
  assign w_unused_addr = ^req_addr[31:IDX_W+2];

  // Single byte anywhere, aligned halfword, or aligned full word.
  function automatic logic strobe_legal(input logic [3:0] be, input logic [1:0] off);
    logic ok;
    ok = (be == (4'b0001 << off))
      || ((be == (4'b0011 << off)) && !off[0])
      || ((be == 4'b1111) && (off == 2'b00));
    return ok;
  endfunction

  initial begin
    for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] = 32'd0;
  end

  assign w_wr_legal = strobe_legal(r_be, r_off);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    w_accept    = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = CNT_INIT;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          // A reset landing on the access edge drops the access.
          w_access    = !reset;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= req_we;
      r_idx   <= req_addr[2 +: IDX_W];
      r_off   <= req_addr[1:0];
      r_wdata <= req_wdata;
      r_be    <= req_be;
    end
  end

  always @(posedge clk) begin
    if (w_access && r_we && w_wr_legal) begin
      for (int b = 0; b < 4; b++) begin
        if (r_be[b]) r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_access) begin
      if (r_we) begin
        r_rdata <= 32'd0;
        r_err   <= !w_wr_legal;
      end else begin
        r_rdata <= r_mem[r_idx];
        r_err   <= 1'b0;
      end
    end
  end

  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_mem_unified_hs.sv
// Bench for mem_unified_hs: directed vector table and random traffic on a
// LATENCY=3 instance, reset/hold corner cases on a LATENCY=4 instance.
module tb_mem_unified_hs;

  localparam int LAT3 = 3;
  localparam int LAT4 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst3, v3, we3, rdy3, rv3, er3;
  logic [31:0] a3, wd3, rd3;
  logic [3:0]  be3;
  logic        rst4, v4, we4, rdy4, rv4, er4;
  logic [31:0] a4, wd4, rd4;
  logic [3:0]  be4;

  mem_unified_hs #(.DEPTH_WORDS(64), .LATENCY(LAT3), .INIT_FILE("")) u3 (
    .clk(clk), .reset(rst3), .req_valid(v3), .req_ready(rdy3), .req_we(we3),
    .req_addr(a3), .req_wdata(wd3), .req_be(be3),
    .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(er3));

  mem_unified_hs #(.DEPTH_WORDS(64), .LATENCY(LAT4), .INIT_FILE("")) u4 (
    .clk(clk), .reset(rst4), .req_valid(v4), .req_ready(rdy4), .req_we(we4),
    .req_addr(a4), .req_wdata(wd4), .req_be(be4),
    .rsp_valid(rv4), .rsp_rdata(rd4), .rsp_err(er4));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference memory: 64 words, all zero at start (no init image).
  logic [31:0] mdl [64];

  // Legal strobe = contiguous run of 1, 2 or 4 bytes starting at the
  // address offset, with the offset a multiple of the run length.
  function automatic bit legal_be(input logic [3:0] be, input logic [1:0] off);
    int n;
    n = int'(be[0]) + int'(be[1]) + int'(be[2]) + int'(be[3]);
    if (!(n == 1 || n == 2 || n == 4)) return 1'b0;
    if ((int'(off) % n) != 0) return 1'b0;
    return be == 4'(((1 << n) - 1) << off);
  endfunction

  task automatic model_apply(input logic we, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] be, output logic [31:0] rd, output logic er);
    int idx;
    idx = int'(a[7:2]);
    rd  = 32'd0;
    er  = 1'b0;
    if (!we) begin
      rd = mdl[idx];
    end else if (legal_be(be, a[1:0])) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mdl[idx][8*b +: 8] = wd[8*b +: 8];
    end else begin
      er = 1'b1;
    end
  endtask

  // One transaction on u3. cyc = cycles from the acceptance cycle to the
  // response cycle; rdy_ok = ready low throughout and back high after.
  task automatic xact3(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, output logic [31:0] rd, output logic er,
                       output int cyc, output bit rdy_ok);
    int n;
    @(negedge clk);
    v3 = 1'b1; we3 = we; a3 = a; wd3 = wd; be3 = be;
    n = 0;
    while (!rdy3 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    v3 = 1'b0;
    cyc = 1; rdy_ok = 1'b1;
    while (!rv3 && cyc < 50) begin
      if (rdy3) rdy_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    rd = rd3; er = er3;
    if (rdy3) rdy_ok = 1'b0;
    @(posedge clk); #1;
    if (!rdy3 || rv3) rdy_ok = 1'b0;
  endtask

  task automatic xact4(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, output logic [31:0] rd, output logic er,
                       output int cyc);
    int n;
    @(negedge clk);
    v4 = 1'b1; we4 = we; a4 = a; wd4 = wd; be4 = be;
    n = 0;
    while (!rdy4 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    v4 = 1'b0;
    cyc = 1;
    while (!rv4 && cyc < 50) begin @(posedge clk); #1; cyc++; end
    rd = rd4; er = er4;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_er;
  } vec_t;

  initial begin
    automatic vec_t        vt [14];
    automatic logic [31:0] rd, mrd, a, wd;
    automatic logic        er, mer, we;
    automatic logic [3:0]  be;
    automatic int          cyc, n, pulses;
    automatic bit          rdy_ok;
    automatic logic [11:0] rv_mask, rdy_mask;

    vt[0]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'h0,        1'b0};
    vt[1]  = '{1'b1, 32'h20,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vt[2]  = '{1'b0, 32'h20,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vt[3]  = '{1'b1, 32'h40,  32'h11223344, 4'hF, 32'h0,        1'b0};
    vt[4]  = '{1'b1, 32'h43,  32'hAA000000, 4'h8, 32'h0,        1'b0};
    vt[5]  = '{1'b0, 32'h40,  32'h0,        4'h0, 32'hAA223344, 1'b0};
    vt[6]  = '{1'b1, 32'h40,  32'h0000BBCC, 4'h3, 32'h0,        1'b0};
    vt[7]  = '{1'b0, 32'h40,  32'h0,        4'h0, 32'hAA22BBCC, 1'b0};
    vt[8]  = '{1'b1, 32'h41,  32'h0000FFFF, 4'h3, 32'h0,        1'b1};
    vt[9]  = '{1'b1, 32'h42,  32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    vt[10] = '{1'b1, 32'h40,  32'hFFFFFFFF, 4'h0, 32'h0,        1'b1};
    vt[11] = '{1'b0, 32'h43,  32'h0,        4'h5, 32'hAA22BBCC, 1'b0};
    vt[12] = '{1'b1, 32'h104, 32'h12345678, 4'hF, 32'h0,        1'b0};
    vt[13] = '{1'b0, 32'h004, 32'h0,        4'h0, 32'h12345678, 1'b0};

    for (int i = 0; i < 64; i++) mdl[i] = 32'd0;
    rst3 = 1'b1; v3 = 1'b0; we3 = 1'b0; a3 = 32'd0; wd3 = 32'd0; be3 = 4'd0;
    rst4 = 1'b1; v4 = 1'b0; we4 = 1'b0; a4 = 32'd0; wd4 = 32'd0; be4 = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst3 = 1'b0; rst4 = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready", 32'(rdy3), 32'd1);
    chk("rst_rsp_valid", 32'(rv3), 32'd0);
    chk("rst_rdata", rd3, 32'd0);
    chk("rst_err", 32'(er3), 32'd0);

    for (int i = 0; i < 14; i++) begin
      xact3(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be, rd, er, cyc, rdy_ok);
      model_apply(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be, mrd, mer);
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].exp_er));
      chk($sformatf("vec%0d_latency", i), 32'(cyc), 32'(LAT3 + 1));
      chk($sformatf("vec%0d_ready", i), 32'(rdy_ok), 32'd1);
    end

    // Response data holds while idle.
    repeat (3) @(posedge clk);
    #1 chk("hold_rdata", rd3, 32'h12345678);

    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom_range(0, 1));
      a  = ($urandom() & 32'hFFFF_FF00) | 32'($urandom_range(0, 31));
      wd = $urandom();
      if ($urandom_range(0, 1) == 0) begin
        be = 4'($urandom_range(0, 15));
      end else begin
        n  = ($urandom_range(0, 2) == 0) ? 4 : (($urandom_range(0, 1) == 0) ? 2 : 1);
        be = 4'(((1 << n) - 1) << a[1:0]);
      end
      xact3(we, a, wd, be, rd, er, cyc, rdy_ok);
      model_apply(we, a, wd, be, mrd, mer);
      chk($sformatf("rnd%0d_rdata", i), rd, mrd);
      chk($sformatf("rnd%0d_err", i), 32'(er), 32'(mer));
      chk($sformatf("rnd%0d_latency", i), 32'(cyc), 32'(LAT3 + 1));
    end

    // Mid-transaction reset on the LATENCY=4 instance drops the write.
    xact4(1'b1, 32'h8, 32'hCAFE0001, 4'hF, rd, er, cyc);
    chk("l4_latency", 32'(cyc), 32'(LAT4 + 1));
    @(negedge clk);
    v4 = 1'b1; we4 = 1'b1; a4 = 32'h8; wd4 = 32'h5; be4 = 4'hF;
    @(posedge clk); #1;
    v4 = 1'b0;
    chk("l4_busy", 32'(rdy4), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst4 = 1'b1;
    @(posedge clk); #1;
    rst4 = 1'b0;
    chk("l4_ready_after_reset", 32'(rdy4), 32'd1);
    chk("l4_err_after_reset", 32'(er4), 32'd0);
    chk("l4_rdata_after_reset", rd4, 32'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (rv4) pulses++;
      @(posedge clk); #1;
    end
    chk("l4_no_pulse", 32'(pulses), 32'd0);
    xact4(1'b0, 32'h8, 32'h0, 4'h0, rd, er, cyc);
    chk("l4_word_kept", rd, 32'hCAFE0001);

    // Request held high: accepted every LATENCY+2 cycles, never during WAIT.
    // Accepts at edges 0 and 6, so responses follow edges 4 and 10 and
    // ready returns after edges 5 and 11.
    @(negedge clk);
    v4 = 1'b1; we4 = 1'b0; a4 = 32'h8; be4 = 4'h0;
    @(posedge clk); #1;
    rv_mask = 12'd0; rdy_mask = 12'd0;
    for (int i = 0; i < 12; i++) begin
      rv_mask[i]  = rv4;
      rdy_mask[i] = rdy4;
      if (i < 11) begin @(posedge clk); #1; end
    end
    v4 = 1'b0;
    chk("l4_hold_rsp_pattern", 32'(rv_mask), 32'h410);
    chk("l4_hold_ready_pattern", 32'(rdy_mask), 32'h820);
    chk("l4_hold_rdata", rd4, 32'hCAFE0001);
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
